// File: rtl/store_trace_buffer_pkg.sv
// Shared widths and the trace entry layout for the store trace buffer and its bench.
package store_trace_buffer_pkg;

    localparam int unsigned ADR_W  = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } trace_entry_t;

    localparam int unsigned ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/store_trace_buffer_if.sv
// Core memory tap plus trace drain port; slave is the buffer, master is the core/consumer side.
interface store_trace_buffer_if
    import store_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] writedata;
    logic              memwrite;
    logic              out_valid;
    logic              out_ready;
    logic [ADR_W-1:0]  out_adr;
    logic [DATA_W-1:0] out_data;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  store_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              overflow;
    logic              halt;

    modport slave (
        input  adr, writedata, memwrite, out_ready,
        output out_valid, out_adr, out_data, level, store_cnt, drop_cnt, overflow, halt
    );

    modport master (
        output adr, writedata, memwrite, out_ready,
        input  out_valid, out_adr, out_data, level, store_cnt, drop_cnt, overflow, halt
    );

endinterface

// File: rtl/store_trace_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO; when empty the read port holds the last popped word.
module store_trace_buffer_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_last;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_rdata   = o_empty ? r_last : r_mem[r_rd_ptr];

    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/store_trace_buffer.sv
// Passive store tap: queues every core store as {adr, data}, counts drops, flags end-of-program.
module store_trace_buffer
    import store_trace_buffer_pkg::*;
#(
    parameter int unsigned     DEPTH    = 8,
    parameter logic [ADR_W-1:0] HALT_ADR = 32'h0000_004C,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    store_trace_buffer_if.slave  bus
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    trace_entry_t     w_wr_entry;
    trace_entry_t     w_rd_entry;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_drop;
    logic [LVL_W-1:0] w_level;
    logic [CNT_W-1:0] r_store_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;
    logic             r_halt;

    assign w_wr_entry = '{adr: bus.adr, data: bus.writedata};
    assign w_push     = bus.memwrite & ~r_halt;
    assign w_pop      = bus.out_ready & ~w_empty;
    assign w_accept   = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;

    store_trace_buffer_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_store_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_halt      <= 1'b0;
        end else begin
            if (w_accept && (r_store_cnt != {CNT_W{1'b1}})) r_store_cnt <= r_store_cnt + 1'b1;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}}))    r_drop_cnt  <= r_drop_cnt + 1'b1;
            if (w_drop)                                     r_overflow  <= 1'b1;
            // Matches fetches as well as data accesses.
            if (bus.adr == HALT_ADR)                        r_halt      <= 1'b1;
        end
    end

    assign bus.out_valid = ~w_empty;
    assign bus.out_adr   = w_rd_entry.adr;
    assign bus.out_data  = w_rd_entry.data;
    assign bus.level     = w_level;
    assign bus.store_cnt = r_store_cnt;
    assign bus.drop_cnt  = r_drop_cnt;
    assign bus.overflow  = r_overflow;
    assign bus.halt      = r_halt;

endmodule

// File: doc/store_trace_buffer.md
Name: store_trace_buffer

Overview:
Passive bus tap on the processor's unified memory interface (adr, writedata, memwrite), sitting directly downstream of the core.
- Captures every store into a FIFO of {address, data} pairs.
- Drains the FIFO to a trace consumer over a valid/ready port.
- Raises a sticky halt when the core drives a programmed end-of-program address, replacing ad-hoc stop checks in simulation.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
HALT_ADR, 32'h0000004C, bus address that sets halt.
CNT_W, 16, width of the store and drop counters.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
adr  input  32  core memory address (fetch or data).
writedata  input  32  core store data.
memwrite  input  1  core store strobe, sampled on the rising edge.
out_valid  output  1  FIFO head valid.
out_ready  input  1  consumer accepts the head.
out_adr  output  32  head entry address.
out_data  output  32  head entry data.
level  output  $clog2(DEPTH)+1  current FIFO occupancy.
store_cnt  output  CNT_W  stores accepted into the FIFO; saturates at all-ones.
drop_cnt  output  CNT_W  stores lost because the FIFO was full; saturates.
overflow  output  1  sticky; set on the first drop.
halt  output  1  sticky end-of-program flag.

Behaviour:
- Reset (asynchronous, active-high): level=0, out_valid=0, out_adr=0, out_data=0, store_cnt=0, drop_cnt=0, overflow=0, halt=0. Reset mid-drain discards all entries.
- Push condition, evaluated each rising edge: memwrite=1 and halt=0.
- Pop condition: out_valid=1 and out_ready=1.
- Push with FIFO not full: write {adr, writedata} at the write pointer and increment store_cnt.
  - Address is stored verbatim; no alignment masking.
- Push with FIFO full and no pop: entry dropped, drop_cnt increments, overflow set.
- Push and pop in the same cycle when full: both succeed, level unchanged, no drop.
- Push and pop in the same cycle when empty: the push succeeds. There is no bypass, so the entry appears one cycle later.
- Latency: an entry pushed at edge N is visible at out_* after edge N.
  - out_valid=1 whenever level>0.
  - out_adr/out_data show the head entry (show-ahead) and hold stable while out_valid=1 and out_ready=0.
- out_adr/out_data when empty: hold the last popped value. Consumers must not use them when out_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- Halt: set at the first rising edge where adr==HALT_ADR, whether fetch or data; cleared only by reset.
  - A store on the same edge that sets halt is still captured, because the halt=0 check uses the pre-edge value.
  - After halt, no further pushes occur. Draining continues normally.
- Counters saturate at 2^CNT_W-1 and never wrap.
- overflow and halt are independent. Neither blocks popping.

Decomposition:
- Shared package: DATA_W=32, ADR_W=32 constants, and the trace entry struct {adr, data}, also reused by the bench scoreboard.
- One natural sub-module: sync_fifo (parameterised DEPTH and width; push/pop/full/empty/level; show-ahead read). store_trace_buffer wraps it with the tap logic, counters and halt detect.

Test Plan:
- Reset then 3 stores: (0x10,0xAA), (0x14,0xBB), (0x18,0xCC), out_ready=1 throughout -> entries appear in order, one per cycle after a 1-cycle lag; store_cnt=3; level returns to 0.
- out_ready=0, 10 stores with DEPTH=8 -> level=8, drop_cnt=2, overflow=1. Then drain with out_ready=1 -> first 8 entries in order; the 9th and 10th are absent.
- FIFO full, simultaneous store and pop -> level stays 8, drop_cnt unchanged, the new entry is at the tail after 8 pops.
- Fetch at adr=0x4C with memwrite=0 -> halt=1 after that edge. Then a store at 0x20 -> not captured, store_cnt unchanged; remaining entries still drain.
- Store at adr=0x4C -> halt=1 and the entry (0x4C,data) is captured.
- Assert reset asynchronously mid-drain with level=5 -> all outputs return to reset values before the next clock edge; a subsequent store is the only entry delivered.
